// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: ID/EXE pipeline register with bubble insertion, hold, deferred flush and saturating bubble counter
module id_exe_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EXE_dstall,
  input  logic             flush,
  input  logic             hold,
  input  logic [XLEN-1:0]  ID_pc,
  input  logic [XLEN-1:0]  ID_rs1_data,
  input  logic [XLEN-1:0]  ID_rs2_data,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic [1:0]       ID_data_to_reg,
  input  logic             ID_reg_write,
  input  logic             ID_mem_write,
  input  logic             ID_alu_src,
  input  logic [3:0]       ID_alu_ctrl,
  input  logic [1:0]       ID_branch,
  output logic [XLEN-1:0]  ID_EXE_pc,
  output logic [XLEN-1:0]  ID_EXE_rs1_data,
  output logic [XLEN-1:0]  ID_EXE_rs2_data,
  output logic [XLEN-1:0]  ID_EXE_imm,
  output logic [4:0]       ID_EXE_rs1,
  output logic [4:0]       ID_EXE_rs2,
  output logic [4:0]       ID_EXE_written_reg,
  output logic [1:0]       ID_EXE_data_to_reg,
  output logic             ID_EXE_reg_write,
  output logic             ID_EXE_mem_write,
  output logic             ID_EXE_alu_src,
  output logic [3:0]       ID_EXE_alu_ctrl,
  output logic [1:0]       ID_EXE_branch,
  output logic             ID_EXE_valid,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int W = 4 * XLEN + 26;
  logic [W-1:0] q;
  logic         pend_flush;
  assign {ID_EXE_pc, ID_EXE_rs1_data, ID_EXE_rs2_data, ID_EXE_imm, ID_EXE_rs1, ID_EXE_rs2,
          ID_EXE_written_reg, ID_EXE_data_to_reg, ID_EXE_reg_write, ID_EXE_mem_write,
          ID_EXE_alu_src, ID_EXE_alu_ctrl, ID_EXE_branch} = q;
  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= '0;
      ID_EXE_valid <= 1'b0;
      bubble_cnt   <= '0;
      pend_flush   <= 1'b0;
    end else if (hold) begin
      pend_flush <= pend_flush | flush;
    end else if (flush | pend_flush | ID_EXE_dstall) begin
      q            <= '0;
      ID_EXE_valid <= 1'b0;
      bubble_cnt   <= bubble_cnt + CNT_W'(~&bubble_cnt);
      pend_flush   <= 1'b0;
    end else begin
      q <= {ID_pc, ID_rs1_data, ID_rs2_data, ID_imm, ID_rs1, ID_rs2, ID_rd, ID_data_to_reg,
            ID_reg_write, ID_mem_write, ID_alu_src, ID_alu_ctrl, ID_branch};
      ID_EXE_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb_id_exe_pipe_reg: randomized and directed checks of id_exe_pipe_reg against a transaction-level model
module tb_id_exe_pipe_reg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  data_to_reg;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  branch;
  } instr_t;
  logic clk = 0, rst = 0, dstall = 0, flush = 0, hold = 0;
  instr_t in_i;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [1:0]  o_dtr, o_branch;
  logic        o_rw, o_mw, o_as, o_valid;
  logic [3:0]  o_ac, o_cnt;
  instr_t exp_i;
  logic   exp_valid, exp_pend;
  int     exp_cnt;
  int     checks = 0, errors = 0;
  id_exe_pipe_reg #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ID_EXE_dstall(dstall), .flush(flush), .hold(hold),
    .ID_pc(in_i.pc), .ID_rs1_data(in_i.rs1_data), .ID_rs2_data(in_i.rs2_data), .ID_imm(in_i.imm),
    .ID_rs1(in_i.rs1), .ID_rs2(in_i.rs2), .ID_rd(in_i.rd), .ID_data_to_reg(in_i.data_to_reg),
    .ID_reg_write(in_i.reg_write), .ID_mem_write(in_i.mem_write), .ID_alu_src(in_i.alu_src),
    .ID_alu_ctrl(in_i.alu_ctrl), .ID_branch(in_i.branch),
    .ID_EXE_pc(o_pc), .ID_EXE_rs1_data(o_rs1_data), .ID_EXE_rs2_data(o_rs2_data), .ID_EXE_imm(o_imm),
    .ID_EXE_rs1(o_rs1), .ID_EXE_rs2(o_rs2), .ID_EXE_written_reg(o_rd), .ID_EXE_data_to_reg(o_dtr),
    .ID_EXE_reg_write(o_rw), .ID_EXE_mem_write(o_mw), .ID_EXE_alu_src(o_as),
    .ID_EXE_alu_ctrl(o_ac), .ID_EXE_branch(o_branch), .ID_EXE_valid(o_valid), .bubble_cnt(o_cnt)
  );
  always #5 clk = ~clk;
  function automatic instr_t observed();
    return {o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_dtr, o_rw, o_mw, o_as, o_ac, o_branch};
  endfunction
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic rand_in();
    in_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_i = '0; exp_valid = 0; exp_cnt = 0; exp_pend = 0;
    end else if (hold) begin
      exp_pend = exp_pend || flush;
    end else if (flush || exp_pend || dstall) begin
      exp_i = '0; exp_valid = 0; exp_pend = 0;
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    end else begin
      exp_i = in_i; exp_valid = 1;
    end
    #1;
    check("fields", observed(), exp_i);
    check("valid", o_valid, exp_valid);
    check("count", o_cnt, exp_cnt);
  endtask
  task automatic drive(input logic r, input logic h, input logic f, input logic d);
    rst = r; hold = h; flush = f; dstall = d;
  endtask
  initial begin
    instr_t snap;
    exp_i = '0; exp_valid = 0; exp_cnt = 0; exp_pend = 0;
    rand_in();
    drive(1, 0, 0, 0); step(); step();
    check("rst_zero", {observed(), o_valid, o_cnt}, '0);
    drive(0, 0, 0, 0); rand_in(); in_i.rd = 5; in_i.data_to_reg = 2'b01; step();
    check("post_rst_rd", {o_rd, o_dtr, o_valid}, {5'd5, 2'b01, 1'b1});
    rand_in(); in_i.rd = 7; in_i.data_to_reg = 2'b01; step();
    check("load_rd", o_rd, 7);
    rand_in(); drive(0, 0, 0, 1); step();
    check("lu_bubble", {o_rd, o_valid, o_cnt}, {5'd0, 1'b0, 4'd1});
    drive(0, 0, 0, 0); step();
    check("lu_reload", {observed(), o_valid}, {in_i, 1'b1});
    snap = observed();
    rand_in(); drive(0, 1, 0, 0); step();
    rand_in(); drive(0, 1, 1, 0); step();
    rand_in(); drive(0, 1, 0, 1); step();
    check("hold_frozen", {observed(), o_cnt}, {snap, 4'd1});
    rand_in(); drive(0, 0, 0, 0); step();
    check("hold_flush_bubble", {o_valid, o_cnt}, {1'b0, 4'd2});
    rand_in(); step();
    check("hold_flush_once", {o_valid, o_cnt}, {1'b1, 4'd2});
    rand_in(); drive(0, 0, 1, 1); step();
    check("flush_dstall", {o_valid, o_cnt}, {1'b0, 4'd3});
    rand_in(); drive(0, 0, 0, 0); step();
    rand_in(); drive(0, 1, 0, 1); step();
    check("hold_dstall", {o_valid, o_cnt}, {1'b1, 4'd3});
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin rand_in(); step(); end
    check("saturate", o_cnt, 15);
    rand_in(); drive(0, 1, 1, 0); step();
    drive(1, 1, 0, 0); step();
    rand_in(); drive(0, 0, 0, 0); step();
    check("rst_pend", {o_valid, o_cnt}, {1'b1, 4'd0});
    for (int i = 0; i < 400; i++) begin
      rand_in();
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

Decode-to-execute pipeline register for the RV32I five-stage core. It captures decoded operands and control from ID and presents them to EXE. It inserts a bubble on a load-use data stall or a control-hazard flush, and holds its contents during a global memory stall. Its `ID_EXE_written_reg` and `ID_EXE_data_to_reg` outputs feed the load-use hazard detector in the same cycle. A saturating counter records inserted bubbles for performance analysis.

## Interface
Parameters:
- `XLEN`, 32: datapath width for PC, operands and immediate.
- `CNT_W`, 32: bubble counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ID_EXE_dstall` in 1: load-use stall from the hazard detector; loads a bubble at the next edge.
- `flush` in 1: branch/jump taken in EXE; loads a bubble at the next edge.
- `hold` in 1: global memory stall; freezes all registers.
- `ID_pc` in XLEN: PC of the decoded instruction.
- `ID_rs1_data`, `ID_rs2_data` in XLEN: register file read data.
- `ID_imm` in XLEN: sign-extended immediate.
- `ID_rs1`, `ID_rs2`, `ID_rd` in 5: source and destination register indices.
- `ID_data_to_reg` in 2: write-back select. 00 = ALU, 01 = memory (load), 10 = PC+4, 11 = immediate.
- `ID_reg_write`, `ID_mem_write`, `ID_alu_src` in 1: control bits.
- `ID_alu_ctrl` in 4: ALU operation.
- `ID_branch` in 2: 00 = none, 01 = conditional, 10 = jal, 11 = jalr.
- `ID_EXE_*` out, same widths as the matching `ID_*` input: registered copies. The rd copy is named `ID_EXE_written_reg`.
- `ID_EXE_valid` out 1: stage holds a real instruction.
- `bubble_cnt` out CNT_W: count of bubbles inserted.

## Operation
Per-edge action, in priority order:
1. **rst**: all outputs go to 0, `ID_EXE_valid` = 0, `bubble_cnt` = 0, `pend_flush` = 0.
2. **hold**: all pipeline fields and `bubble_cnt` are unchanged. If `flush` = 1 this cycle, `pend_flush` is set to 1. `ID_EXE_dstall` is ignored, because the detector re-evaluates once the hold is released.
3. **flush, pend_flush or ID_EXE_dstall** (hold = 0): load a bubble and clear `pend_flush`.
4. **Otherwise**: load all `ID_*` inputs and set `ID_EXE_valid` = 1.

Bubble contents:
- Every output field is zero: `written_reg` = 0, `data_to_reg` = 00, `reg_write` = 0, `mem_write` = 0, `branch` = 00, and PC, operands and immediate are all zero.
- `ID_EXE_valid` = 0.
- The all-zero encoding means the bubble never triggers the hazard detector (it has `written_reg` = 0) and never writes state.

Bubble counter:
- Increments by 1 for each bubble loaded in action 3.
- Saturates at all-ones and never wraps.
- Not incremented on rst or hold.
- Simultaneous flush and dstall loads one bubble and counts +1.

No combinational path from inputs to outputs; all outputs are direct register outputs.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Load-use sequence:
  - Load in EXE, dependent instruction in ID.
  - The detector asserts `ID_EXE_dstall` combinationally in the same cycle.
  - At the next edge a bubble enters EXE, while IF/ID and the PC are held by their own stall signals.
  - The following cycle the detector deasserts and the dependent instruction loads normally.
- A flush asserted during hold for any number of cycles is applied exactly once: at the first edge with hold = 0.
- Reset mid-hold or with a pending flush clears everything, including `pend_flush`.
- `hold` held continuously keeps all outputs constant indefinitely.

## Test plan
- **Reset**: drive random inputs, assert rst for 2 cycles. All outputs are 0 and `bubble_cnt` = 0. After release, `ID_rd` = 5 and `ID_data_to_reg` = 01 appear at the next edge with valid = 1.
- **Load-use**: load `ID_rd` = 7, `data_to_reg` = 01, then pulse `ID_EXE_dstall` for 1 cycle. The next edge gives `written_reg` = 0, valid = 0, `bubble_cnt` = 1. The edge after that loads the presented instruction.
- **Hold with flush**: hold = 1 for 3 cycles with flush pulsed in the 2nd. Outputs stay frozen. At the first edge after hold drops a bubble loads, `bubble_cnt` +1 exactly once, and the following edge loads normally.
- **Simultaneous events**: flush and dstall together load one bubble, count +1. Hold with dstall loads nothing, count +0.
- **Saturation**: with CNT_W = 4, insert 20 bubbles. `bubble_cnt` stops at 15.
- **Reset mid-pending**: set `pend_flush` via flush during hold, assert rst, then release both. No bubble is inserted; the first post-reset instruction loads with valid = 1.
